// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: instruction fetch (port 0) and load/store (port 1)
// share one memory port, one outstanding transaction, response timeout.
module mem_port_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [1:0]  req_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    input  logic [1:0]  we_i,
    input  logic [3:0]  wstrb0_i,
    input  logic [3:0]  wstrb1_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } state_t;

    state_t      state;
    logic        owner;
    logic        last_owner;
    logic [15:0] cnt;
    logic        win;

    // Winner: lone requester, or on a tie the port that did not win last.
    always_comb begin
        win = 1'b0;
        case (req_i)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_owner;
            default: win = 1'b0;
        endcase
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cnt        <= '0;
            gnt_o      <= '0;
            rvalid_o   <= '0;
            rdata_o    <= '0;
            err_o      <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            gnt_o    <= '0;
            rvalid_o <= '0;
            err_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i != 2'b00) begin
                        owner      <= win;
                        last_owner <= win;
                        gnt_o      <= win ? 2'b10 : 2'b01;
                        mem_req    <= 1'b1;
                        mem_we     <= we_i[win];
                        mem_addr   <= win ? addr1_i : addr0_i;
                        mem_wstrb  <= win ? wstrb1_i : wstrb0_i;
                        mem_wdata  <= win ? wdata1_i : wdata0_i;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        state   <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    // A response on the expiry cycle still counts as normal.
                    if (mem_rvalid) begin
                        rvalid_o <= owner ? 2'b10 : 2'b01;
                        rdata_o  <= mem_rdata;
                        state    <= IDLE;
                    end else if (cnt == CNT_MAX) begin
                        rvalid_o <= owner ? 2'b10 : 2'b01;
                        rdata_o  <= '0;
                        err_o    <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4); inputs driven and
// outputs sampled on the falling edge, DUT updates on the rising edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        nreset;
    logic [1:0]  req_i;
    logic [31:0] addr0_i, addr1_i;
    logic [1:0]  we_i;
    logic [3:0]  wstrb0_i, wstrb1_i;
    logic [31:0] wdata0_i, wdata1_i;
    logic [1:0]  gnt_o, rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .nreset(nreset), .req_i(req_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .we_i(we_i),
        .wstrb0_i(wstrb0_i), .wstrb1_i(wstrb1_i),
        .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // From ISSUE: memory accepts this cycle, leaves the DUT in WAIT_RESP.
    task automatic accept();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
    endtask

    // From WAIT_RESP entry: wait `dly` cycles, then return `data`.
    task automatic respond(input int dly, input logic [31:0] data);
        for (int i = 0; i < dly; i++) step();
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        step();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        nreset = 1'b0; req_i = '0; we_i = '0;
        addr0_i = '0; addr1_i = '0;
        wstrb0_i = '0; wstrb1_i = '0;
        wdata0_i = '0; wdata1_i = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        step(); step();

        // Reset state
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_rvalid", 32'(rvalid_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);

        // Single fetch on port 0
        nreset = 1'b1;
        req_i = 2'b01; addr0_i = 32'h8000_0000;
        step();
        check("f_gnt", 32'(gnt_o), 32'h1);
        check("f_mem_req", 32'(mem_req), 32'h1);
        check("f_mem_addr", mem_addr, 32'h8000_0000);
        check("f_mem_we", 32'(mem_we), 32'h0);
        req_i = 2'b00; addr0_i = 32'hdead_0000;
        accept();
        check("f_mem_req_off", 32'(mem_req), 32'h0);
        check("f_gnt_pulse", 32'(gnt_o), 32'h0);
        respond(2, 32'h0000_0013);
        check("f_rvalid", 32'(rvalid_o), 32'h1);
        check("f_rdata", rdata_o, 32'h0000_0013);
        check("f_err", 32'(err_o), 32'h0);
        step();
        check("f_rvalid_pulse", 32'(rvalid_o), 32'h0);

        // Response on the expiry cycle is a normal response
        req_i = 2'b10; addr1_i = 32'h0000_4000;
        step();
        check("e_gnt", 32'(gnt_o), 32'h2);
        req_i = 2'b00;
        accept();
        respond(3, 32'h1234_5678);
        check("e_rvalid", 32'(rvalid_o), 32'h2);
        check("e_err", 32'(err_o), 32'h0);
        check("e_rdata", rdata_o, 32'h1234_5678);

        // Round robin with both ports requesting from reset
        nreset = 1'b0;
        step();
        nreset = 1'b1; req_i = 2'b11;
        for (int t = 0; t < 4; t++) begin
            logic [1:0] e;
            e = (t % 2 == 0) ? 2'b01 : 2'b10;
            step();
            check($sformatf("rr_gnt%0d", t), 32'(gnt_o), 32'(e));
            accept();
            respond(0, 32'(t));
            check($sformatf("rr_rv%0d", t), 32'(rvalid_o), 32'(e));
            check($sformatf("rr_nogn%0d", t), 32'(gnt_o), 32'h0);
        end
        req_i = 2'b00;
        step();

        // Port 1 store with a slow mem_ready
        req_i = 2'b10; we_i = 2'b10; addr1_i = 32'h8000_1000;
        wstrb1_i = 4'b0011; wdata1_i = 32'h0000_beef;
        step();
        check("s_gnt", 32'(gnt_o), 32'h2);
        check("s_we", 32'(mem_we), 32'h1);
        check("s_wstrb", 32'(mem_wstrb), 32'h3);
        req_i = 2'b00; we_i = 2'b00; addr1_i = 32'h1111_1111;
        wstrb1_i = 4'b1111; wdata1_i = 32'h2222_2222;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("s_req%0d", i), 32'(mem_req), 32'h1);
            check($sformatf("s_addr%0d", i), mem_addr, 32'h8000_1000);
            check($sformatf("s_wdata%0d", i), mem_wdata, 32'h0000_beef);
            if (i == 4) mem_ready = 1'b1;
            step();
        end
        mem_ready = 1'b0;
        check("s_req_off", 32'(mem_req), 32'h0);
        respond(0, 32'h0000_00aa);
        check("s_rvalid", 32'(rvalid_o), 32'h2);
        check("s_err", 32'(err_o), 32'h0);

        // Timeout with no response, then a late response
        req_i = 2'b01; addr0_i = 32'h8000_0040;
        step();
        check("t_gnt", 32'(gnt_o), 32'h1);
        req_i = 2'b00;
        accept();
        for (int i = 1; i < 4; i++) begin
            step();
            check($sformatf("t_wait%0d", i), 32'(rvalid_o), 32'h0);
        end
        step();
        check("t_rvalid", 32'(rvalid_o), 32'h1);
        check("t_err", 32'(err_o), 32'h1);
        check("t_rdata", rdata_o, 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        step();
        mem_rvalid = 1'b0;
        check("t_late_rv", 32'(rvalid_o), 32'h0);
        check("t_late_err", 32'(err_o), 32'h0);

        // Reset during WAIT_RESP, stray response, then a tie
        req_i = 2'b01; addr0_i = 32'h8000_0080;
        step();
        check("r_gnt", 32'(gnt_o), 32'h1);
        req_i = 2'b00;
        accept();
        nreset = 1'b0;
        step();
        check("r_mem_req", 32'(mem_req), 32'h0);
        nreset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        mem_rvalid = 1'b0;
        check("r_stray_rv", 32'(rvalid_o), 32'h0);
        req_i = 2'b11;
        step();
        check("r_tie_gnt", 32'(gnt_o), 32'h1);
        req_i = 2'b00;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 64, number of cycles WAIT_RESP waits for mem_rvalid before it aborts (legal range 2..65535).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 nreset  input  1  reset, synchronous, active-low.
REQ-004 req_i[1:0]  input  2  request per port; port 0 is instruction fetch, port 1 is load/store.
REQ-005 addr0_i, addr1_i  input  32 each  byte address per port.
REQ-006 we_i[1:0]  input  2  write enable per port (1 = store).
REQ-007 wstrb0_i, wstrb1_i  input  4 each  byte strobes per port.
REQ-008 wdata0_i, wdata1_i  input  32 each  write data per port.
REQ-009 gnt_o[1:0]  output  2  one-cycle pulse; the request on that port was accepted.
REQ-010 rvalid_o[1:0]  output  2  one-cycle pulse; response for that port.
REQ-011 rdata_o  output  32  read data, valid while any rvalid_o bit is high.
REQ-012 err_o  output  1  qualifies rvalid_o; 1 = response timed out.
REQ-013 mem_req, mem_we  output  1 each  memory request and write enable.
REQ-014 mem_addr, mem_wdata  output  32 each; mem_wstrb  output  4.
REQ-015 mem_ready  input  1  memory accepts the request in any cycle where mem_req=1.
REQ-016 mem_rvalid  input  1; mem_rdata  input  32  memory response (read data or write ack).

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT_RESP; one outstanding transaction at most.
REQ-018 IDLE with req_i!=0: select winner, latch addr/we/wstrb/wdata into mem_* registers, pulse gnt_o[winner], set owner=winner, enter ISSUE; all updates at the same edge.
REQ-019 Arbitration: single requester wins; both requesting -> grant the port not equal to last_owner (round robin); last_owner updates at grant.
REQ-020 Requester may deassert or change req/addr/data after its gnt_o pulse; mem_* stay stable from grant until accepted.
REQ-021 ISSUE: mem_req=1; on mem_ready=1 -> mem_req=0 at the next edge, clear timeout counter, enter WAIT_RESP.
REQ-022 WAIT_RESP: counter increments each cycle; mem_rvalid=1 -> next cycle rvalid_o[owner]=1, rdata_o=mem_rdata, err_o=0, state IDLE.
REQ-023 WAIT_RESP with counter reaching TIMEOUT-1 and mem_rvalid=0 -> next cycle rvalid_o[owner]=1, rdata_o=0, err_o=1, state IDLE.
REQ-024 mem_rvalid in the same cycle as timeout expiry is a normal response, err_o=0.
REQ-025 mem_rvalid outside WAIT_RESP is ignored, including late responses after a timeout.
REQ-026 Latency: req at IDLE cycle N -> gnt_o and mem_req at N+1; mem_rvalid at K -> rvalid_o at K+1 and state IDLE at K+1; earliest next gnt_o is K+2.
REQ-027 gnt_o, rvalid_o, err_o are single-cycle pulses, at most one bit set, all outputs registered.
REQ-028 Writes follow the same flow; rdata_o for a write response is the mem_rdata value, don't-care to requesters.
REQ-029 Counter width is 16 bits and it never wraps; it saturates at TIMEOUT-1.

Reset
REQ-030 nreset=0 at a clock edge: state=IDLE, last_owner=1 (port 0 wins the first tie), counter=0, all outputs 0.
REQ-031 Reset mid-transaction aborts it with no rvalid_o; a subsequent stray mem_rvalid is ignored per REQ-025.

Verification
REQ-032 Only req_i=01, addr0_i=0x80000000, mem_ready=1 at once, mem_rvalid after 3 cycles with rdata 0x00000013 -> gnt_o=01 next cycle, rvalid_o=01 with rdata_o=0x00000013, err_o=0.
REQ-033 req_i=11 held continuously after reset -> grant order 0,1,0,1 over four transactions.
REQ-034 Port 1 store, addr 0x80001000, wstrb 0011, wdata 0x0000BEEF, mem_ready delayed 5 cycles -> mem_* hold stable and mem_req=1 for 5 cycles, then rvalid_o=10.
REQ-035 TIMEOUT=4, mem_rvalid never returned -> rvalid_o[owner]=1 with err_o=1 and rdata_o=0, 4 cycles after entering WAIT_RESP; a late mem_rvalid is then ignored.
REQ-036 nreset=0 during WAIT_RESP, followed by mem_rvalid -> no rvalid_o; state IDLE; next req_i=11 grants port 0.
